ula_arbiter: RTL

//  Shares one ula instance between two requesters, e.g. port 0 = execute stage, port 1 = branch/address unit.
//  Per-port valid/ready handshake, round-robin or fixed-priority grant.

---
 rtl/ula_arbiter_if.sv | 53 +++++
 rtl/ula_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/ula_arbiter_if.sv
// ---------------------------------------------------------------------------
// ula_arbiter_if
// Bundles the two requester ports, the shared-ula connection and the
// response signals of ula_arbiter.
//   req0_* / req1_*  : valid/ready handshake plus operands a, b and op code
//   ula_a/b/op       : operands driven to the shared ula
//   ula_result/zero  : combinational result and zero flag from the ula
//   rsp0/1_valid     : one-cycle response pulse per port
//   rsp_result/zero  : registered result and zero flag of the last transfer
// Modports: slave = arbiter side, master = requesters + ula side.
// ---------------------------------------------------------------------------
interface ula_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] ula_a;
  logic [WIDTH-1:0] ula_b;
  logic [OPW-1:0]   ula_op;
  logic [WIDTH-1:0] ula_result;
  logic             ula_zero;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output ula_a, ula_b, ula_op,
    input  ula_result, ula_zero,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  ula_a, ula_b, ula_op,
    output ula_result, ula_zero,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
// Shares one ula between two requesters. Grant is combinational in the
// request cycle; the ula result and zero flag are captured at the end of
// that cycle and presented with a one-cycle per-port valid pulse.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : ula_arbiter_if.slave (requests, shared-ula link, responses)
// Parameters:
//   WIDTH   : operand/result width
//   OPW     : op code width
//   RR      : 1 = round-robin on tie, 0 = port 0 always wins
//   IDLE_OP : op driven to the ula when nothing is granted
// ---------------------------------------------------------------------------
module ula_arbiter #(
  parameter int             WIDTH   = 32,
  parameter int             OPW     = 4,
  parameter bit             RR      = 1'b1,
  parameter logic [OPW-1:0] IDLE_OP = '0
) (
  input logic          clk,
  input logic          reset,
  ula_arbiter_if.slave bus
);

  logic             last_q, last_d;
  logic             gnt0, gnt1, xfer;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  // Grant: last_q names the port granted most recently, so on a tie the
  // other port wins. Reset blocks every grant so no transfer can happen
  // while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (RR) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // A grant is only ever given to a valid port, so grant implies transfer.
  assign xfer           = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_comb begin
    bus.ula_a  = '0;
    bus.ula_b  = '0;
    bus.ula_op = IDLE_OP;
    if (gnt0) begin
      bus.ula_a  = bus.req0_a;
      bus.ula_b  = bus.req0_b;
      bus.ula_op = bus.req0_op;
    end else if (gnt1) begin
      bus.ula_a  = bus.req1_a;
      bus.ula_b  = bus.req1_b;
      bus.ula_op = bus.req1_op;
    end
  end

  always_comb begin
    last_d       = xfer ? gnt1 : last_q;
    rsp_result_d = xfer ? bus.ula_result : rsp_result_q;
    rsp_zero_d   = xfer ? bus.ula_zero : rsp_zero_q;
  end

  // Response stage: result captured at the end of the transfer cycle.
  // last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      last_q       <= last_d;
      rsp0_valid_q <= gnt0;
      rsp1_valid_q <= gnt1;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
